// File: rtl/axi_wdata_burst_gen.sv
// Burst write-data source: takes one (len, seed, step) command and emits an
// arithmetic-progression beat stream with valid/ready/last, all outputs registered.
module axi_wdata_burst_gen #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_seed,
    input  logic [DATA_W-1:0] cmd_step,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              last_out,
    output logic [LEN_W-1:0]  beat_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic {
        IDLE_S  = 1'b0,
        BURST_S = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic                done_q, done_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   step_q, step_d;
    logic [LEN_W-1:0]    idx_inc_s;

    assign idx_inc_s = idx_q + LEN_W'(1);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE_S;
            cmd_ready_q <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= {DATA_W{1'b0}};
            last_q      <= 1'b0;
            idx_q       <= {LEN_W{1'b0}};
            done_q      <= 1'b0;
            len_q       <= {LEN_W{1'b0}};
            step_q      <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            len_q       <= len_d;
            step_q      <= step_d;
        end
    end

    // Next-state logic: command accept, beat advance, stall hold.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        valid_d     = valid_q;
        data_d      = data_q;
        last_d      = last_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        len_d       = len_q;
        step_d      = step_q;
        case (state_q)
            IDLE_S: begin
                // cmd_ready comes up on the first edge after reset and stays up while idle.
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = BURST_S;
                    cmd_ready_d = 1'b0;
                    valid_d     = 1'b1;
                    data_d      = cmd_seed;
                    idx_d       = {LEN_W{1'b0}};
                    last_d      = (cmd_len == {LEN_W{1'b0}});
                    len_d       = cmd_len;
                    step_d      = cmd_step;
                end else begin
                    valid_d = 1'b0;
                end
            end
            BURST_S: begin
                if (valid_q && ready_in) begin
                    if (last_q) begin
                        state_d     = IDLE_S;
                        cmd_ready_d = 1'b1;
                        valid_d     = 1'b0;
                        last_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        data_d = data_q + step_q;
                        idx_d  = idx_inc_s;
                        last_d = (idx_inc_s == len_q);
                    end
                end else begin
                    valid_d = valid_q;
                end
            end
            default: begin
                state_d     = IDLE_S;
                cmd_ready_d = 1'b0;
                valid_d     = 1'b0;
                last_d      = 1'b0;
            end
        endcase
    end

    assign cmd_ready = cmd_ready_q;
    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign last_out  = last_q;
    assign beat_idx  = idx_q;
    assign busy      = (state_q == BURST_S);
    assign done      = done_q;

endmodule

// File: tb/tb_axi_wdata_burst_gen.sv
// Directed self-checking bench for axi_wdata_burst_gen.
module tb_axi_wdata_burst_gen;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic [31:0] cmd_seed;
    logic [31:0] cmd_step;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] data_out;
    logic        last_out;
    logic [7:0]  beat_idx;
    logic        busy;
    logic        done;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    axi_wdata_burst_gen #(.DATA_W(32), .LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_seed  (cmd_seed),
        .cmd_step  (cmd_step),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .last_out  (last_out),
        .beat_idx  (beat_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Issue one command and follow its burst beat by beat, stalling stall_n cycles on stall_beat.
    task automatic run_burst(input logic [7:0] len, input logic [31:0] seed, input logic [31:0] step,
                             input int stall_beat, input int stall_n);
        logic [31:0] exp_data;
        int beat;
        int hs;
        int stalls;
        int cycles;
        @(negedge clk);
        ready_in  = 1'b1;
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_seed  = seed;
        cmd_step  = step;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_len   = ~len;
        cmd_seed  = 32'hDEAD_BEEF;
        cmd_step  = 32'h0BAD_0BAD;
        exp_data  = seed;
        beat      = 0;
        hs        = 0;
        stalls    = 0;
        cycles    = 0;
        while (beat <= int'(len) && cycles < 600) begin
            @(negedge clk);
            cycles++;
            chk("beat_valid", {31'd0, valid_out}, 32'd1);
            chk("beat_data",  data_out, exp_data);
            chk("beat_last",  {31'd0, last_out}, {31'd0, (beat == int'(len))});
            chk("beat_idx",   {24'd0, beat_idx}, beat[31:0]);
            chk("beat_busy",  {31'd0, busy}, 32'd1);
            if (beat == 16 && seed == 32'hFFFF_FFF0) begin
                chk("wrap_zero", data_out, 32'h0000_0000);
            end else begin
                chk_cnt = chk_cnt;
            end
            if (beat == stall_beat && stalls < stall_n) begin
                ready_in = 1'b0;
                stalls++;
            end else begin
                ready_in = 1'b1;
            end
            if (valid_out && ready_in) begin
                hs++;
                beat++;
                exp_data = exp_data + step;
            end
            @(posedge clk);
        end
        chk("handshakes", hs[31:0], {24'd0, len} + 32'd1);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("post_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_valid", {31'd0, valid_out}, 32'd0);
        chk("post_busy",  {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("done_once",  {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = 8'd0;
        cmd_seed  = 32'd0;
        cmd_step  = 32'd0;
        ready_in  = 1'b0;
        #2;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_valid",     {31'd0, valid_out}, 32'd0);
        chk("rst_data",      data_out, 32'd0);
        chk("rst_idx",       {24'd0, beat_idx}, 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_edge", {31'd0, cmd_ready}, 32'd1);

        // Single beat, full rate, backpressure, wrap with max length.
        run_burst(8'd0,   32'hA5A5_0000, 32'd1,      -1, 0);
        run_burst(8'd3,   32'h0000_0010, 32'd4,      -1, 0);
        run_burst(8'd2,   32'h0000_0100, 32'h100,     1, 3);
        run_burst(8'd255, 32'hFFFF_FFF0, 32'd1,      -1, 0);

        // Back-to-back with cmd_valid held high; junk on the fields until the second accept.
        @(negedge clk);
        ready_in  = 1'b1;
        cmd_valid = 1'b1;
        cmd_len   = 8'd1;
        cmd_seed  = 32'h0000_1000;
        cmd_step  = 32'h0000_0010;
        @(posedge clk);
        #1;
        cmd_len   = 8'd7;
        cmd_seed  = 32'h0000_DEAD;
        cmd_step  = 32'd3;
        @(negedge clk);
        chk("b2b_a0_valid", {31'd0, valid_out}, 32'd1);
        chk("b2b_a0_data",  data_out, 32'h0000_1000);
        chk("b2b_a0_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_a1_data",  data_out, 32'h0000_1010);
        chk("b2b_a1_last",  {31'd0, last_out}, 32'd1);
        @(negedge clk);
        chk("b2b_gap_valid", {31'd0, valid_out}, 32'd0);
        chk("b2b_gap_done",  {31'd0, done}, 32'd1);
        chk("b2b_gap_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_len  = 8'd1;
        cmd_seed = 32'h0000_2000;
        cmd_step = 32'h0000_0020;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_seed  = 32'h0000_BEEF;
        cmd_step  = 32'd9;
        @(negedge clk);
        chk("b2b_b0_valid", {31'd0, valid_out}, 32'd1);
        chk("b2b_b0_data",  data_out, 32'h0000_2000);
        chk("b2b_b0_idx",   {24'd0, beat_idx}, 32'd0);
        @(negedge clk);
        chk("b2b_b1_data",  data_out, 32'h0000_2020);
        chk("b2b_b1_last",  {31'd0, last_out}, 32'd1);
        @(negedge clk);
        chk("b2b_end_valid", {31'd0, valid_out}, 32'd0);
        chk("b2b_end_done",  {31'd0, done}, 32'd1);

        // Reset during beat 2 of a six-beat burst.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len   = 8'd5;
        cmd_seed  = 32'h0000_0050;
        cmd_step  = 32'd5;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_beat2_data", data_out, 32'h0000_005A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
        chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
        chk("mid_rst_data",  data_out, 32'd0);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("mid_rst_done",  {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_rel_done",  {31'd0, done}, 32'd0);
        run_burst(8'd1, 32'h0000_0700, 32'h0000_0011, -1, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
